// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
//   Decoder-to-dispatch micro-instruction queue. A DP-deep circular buffer with
//   first-word fall-through at the head. Fullness, emptiness and occupancy are
//   derived only from the pointer registers, so no input reaches them
//   combinationally. A flush discards every entry on the next edge.
//
// Ports
//   CLK                 in   1         clock, rising edge
//   RSTn                in   1         asynchronous active-low reset
//   instrFifo_push      in   1         write request from the decoder
//   decode_microInstr   in   DW        write data
//   instrFifo_full      out  1         occupancy == DP
//   dispatch_pop        in   1         read request from dispatch
//   instrFifo_empty     out  1         occupancy == 0
//   dispatch_microInstr out  DW        head entry (fall-through)
//   instrFifo_count     out  AW+1      occupancy, 0..DP
//   flush               in   1         discard all entries
// -----------------------------------------------------------------------------
`ifndef DECODE_INFO_DW
`define DECODE_INFO_DW 32
`endif

module instr_fifo #(
  parameter int DW = `DECODE_INFO_DW,
  parameter int DP = 4
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     instrFifo_push,
  input  logic [DW-1:0]            decode_microInstr,
  output logic                     instrFifo_full,
  input  logic                     dispatch_pop,
  output logic                     instrFifo_empty,
  output logic [DW-1:0]            dispatch_microInstr,
  output logic [$clog2(DP):0]      instrFifo_count,
  input  logic                     flush
);

  localparam int AW = $clog2(DP);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits coincide.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] mem_d [DP];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          push_ok;
  logic          pop_ok;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  assign instrFifo_empty = (wr_ptr_q == rd_ptr_q);
  assign instrFifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign instrFifo_count = wr_ptr_q - rd_ptr_q;

  assign dispatch_microInstr = mem_q[rd_idx];

  // Acceptance is judged on registered full/empty, so a push at full is
  // dropped even when a pop frees a slot in the same cycle.
  assign push_ok = instrFifo_push && !instrFifo_full  && !flush;
  assign pop_ok  = dispatch_pop   && !instrFifo_empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DP; i++) mem_d[i] = mem_q[i];
    if (push_ok) mem_d[wr_idx] = decode_microInstr;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head never shows X after reset.
  generate
    for (genvar gi = 0; gi < DP; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) mem_q[gi] <= '0;
        else       mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

endmodule
